cache_ctrl: RTL and testbench

- Controller FSM for the 2-way, 4-set, one-word-per-line write-back data cache.
- Accepts CPU load/store requests and drives the cache tag/data array's write port (write_en, index, victim_way, v/tag/data/dirty).
- Consumes the array's combinational per-set read outputs.
- Runs miss handling (victim select, dirty writeback, refill) against a valid/ack memory port; keeps per-set LRU state.

---
 rtl/cache_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Controller for a 2-way, 4-set, one-word-per-line write-back cache: hit/miss, dirty writeback, refill, per-set LRU.
// Optional CACHE_CTRL_WRITE_NOFETCH_EN: store misses write the line directly instead of refilling it first.
module cache_ctrl #(
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [31:0]                  cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic                         cpu_ready,
    output logic                         cpu_resp_valid,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         arr_write_en,
    output logic [INDEX_W-1:0]           arr_index,
    output logic                         arr_victim_way,
    output logic                         arr_v_write,
    output logic [32-INDEX_W-3:0]        arr_tag_write,
    output logic [DATA_W-1:0]            arr_data_write,
    output logic                         arr_dirty_write,
    input  logic                         arr_v_way0,
    input  logic                         arr_v_way1,
    input  logic                         arr_dirty_way0,
    input  logic                         arr_dirty_way1,
    input  logic [32-INDEX_W-3:0]        arr_tag_way0,
    input  logic [32-INDEX_W-3:0]        arr_tag_way1,
    input  logic [DATA_W-1:0]            arr_data_way0,
    input  logic [DATA_W-1:0]            arr_data_way1
);
    localparam int TAG_W = 32 - INDEX_W - 2;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                vic_q, vic_d;
    logic [TAG_W-1:0]    vic_tag_q, vic_tag_d;
    logic [DATA_W-1:0]   vic_data_q, vic_data_d;
    logic [SETS-1:0]     lru_q, lru_d;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  set_idx;
    logic                hit0, hit1, hit_way, miss_vic, vic_dirty;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr[1:0];
    assign req_tag   = addr_q[31 -: TAG_W];
    assign set_idx   = addr_q[INDEX_W+1:2];
    assign arr_index = set_idx;

    assign hit0      = arr_v_way0 && (arr_tag_way0 == req_tag);
    assign hit1      = arr_v_way1 && (arr_tag_way1 == req_tag);
    assign hit_way   = !hit0;
    // Fill invalid ways first (way0 before way1); only a full set consults LRU.
    assign miss_vic  = !arr_v_way0 ? 1'b0 : (!arr_v_way1 ? 1'b1 : lru_q[set_idx]);
    assign vic_dirty = miss_vic ? (arr_v_way1 && arr_dirty_way1) : (arr_v_way0 && arr_dirty_way0);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        we_d            = we_q;
        wdata_d         = wdata_q;
        vic_d           = vic_q;
        vic_tag_d       = vic_tag_q;
        vic_data_d      = vic_data_q;
        lru_d           = lru_q;
        cpu_ready       = 1'b0;
        cpu_resp_valid  = 1'b0;
        cpu_rdata       = '0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        arr_write_en    = 1'b0;
        arr_victim_way  = 1'b0;
        arr_v_write     = 1'b0;
        arr_tag_write   = req_tag;
        arr_data_write  = wdata_q;
        arr_dirty_write = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit0 || hit1) begin
                    cpu_resp_valid = 1'b1;
                    cpu_rdata      = hit_way ? arr_data_way1 : arr_data_way0;
                    if (we_q) begin
                        arr_write_en    = 1'b1;
                        arr_victim_way  = hit_way;
                        arr_v_write     = 1'b1;
                        arr_dirty_write = 1'b1;
                    end
                    lru_d[set_idx] = ~hit_way;
                    state_d        = IDLE;
                end else begin
                    vic_d      = miss_vic;
                    vic_tag_d  = miss_vic ? arr_tag_way1 : arr_tag_way0;
                    vic_data_d = miss_vic ? arr_data_way1 : arr_data_way0;
                    if (vic_dirty) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = REFILL;
`ifdef CACHE_CTRL_WRITE_NOFETCH_EN
                        if (we_q) begin
                            arr_write_en    = 1'b1;
                            arr_victim_way  = miss_vic;
                            arr_v_write     = 1'b1;
                            arr_dirty_write = 1'b1;
                            cpu_resp_valid  = 1'b1;
                            lru_d[set_idx]  = ~miss_vic;
                            state_d         = IDLE;
                        end
`endif
                    end
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vic_tag_q, set_idx, 2'b00};
                mem_wdata = vic_data_q;
                if (mem_ack) begin
                    state_d = REFILL;
`ifdef CACHE_CTRL_WRITE_NOFETCH_EN
                    if (we_q) begin
                        arr_write_en    = 1'b1;
                        arr_victim_way  = vic_q;
                        arr_v_write     = 1'b1;
                        arr_dirty_write = 1'b1;
                        cpu_resp_valid  = 1'b1;
                        lru_d[set_idx]  = ~vic_q;
                        state_d         = IDLE;
                    end
`endif
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, set_idx, 2'b00};
                if (mem_ack) begin
                    arr_write_en    = 1'b1;
                    arr_victim_way  = vic_q;
                    arr_v_write     = 1'b1;
                    arr_data_write  = we_q ? wdata_q : mem_rdata;
                    arr_dirty_write = we_q;
                    cpu_resp_valid  = 1'b1;
                    cpu_rdata       = mem_rdata;
                    lru_d[set_idx]  = ~vic_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset masks every handshake, including a mem_ack arriving mid-reset.
        if (rst) begin
            cpu_ready      = 1'b0;
            cpu_resp_valid = 1'b0;
            cpu_rdata      = '0;
            mem_req        = 1'b0;
            arr_write_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            vic_q      <= 1'b0;
            vic_tag_q  <= '0;
            vic_data_q <= '0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            vic_q      <= vic_d;
            vic_tag_q  <= vic_tag_d;
            vic_data_q <= vic_data_d;
            lru_q      <= lru_d;
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: behavioural tag/data array and memory responder, queued expectations checked by monitors.
module tb_cache_ctrl;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; } mem_exp_t;
    typedef struct { logic way; logic [1:0] idx; logic [27:0] tag; logic [31:0] data; logic dirty; } arr_exp_t;
    typedef struct { logic chk; logic [31:0] rdata; } resp_exp_t;

    logic        clk = 0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ready, cpu_resp_valid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        arr_write_en, arr_victim_way, arr_v_write, arr_dirty_write;
    logic [1:0]  arr_index;
    logic [27:0] arr_tag_write, arr_tag_way0, arr_tag_way1;
    logic [31:0] arr_data_write, arr_data_way0, arr_data_way1;
    logic        arr_v_way0, arr_v_way1, arr_dirty_way0, arr_dirty_way1;

    logic        auto_ack, man_ack;
    logic [31:0] auto_rdata, man_rdata;
    logic        mem_auto;
    int          ack_delay;
    assign mem_ack   = auto_ack | man_ack;
    assign mem_rdata = auto_rdata | man_rdata;

    mem_exp_t  exp_mem[$];
    arr_exp_t  exp_arr[$];
    resp_exp_t exp_resp[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, resp_cnt = 0, last_resp_cyc = 0, mem_req_cyc = 0, acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_ctrl #(.DATA_W(32), .INDEX_W(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .arr_write_en(arr_write_en), .arr_index(arr_index), .arr_victim_way(arr_victim_way),
        .arr_v_write(arr_v_write), .arr_tag_write(arr_tag_write), .arr_data_write(arr_data_write),
        .arr_dirty_write(arr_dirty_write),
        .arr_v_way0(arr_v_way0), .arr_v_way1(arr_v_way1),
        .arr_dirty_way0(arr_dirty_way0), .arr_dirty_way1(arr_dirty_way1),
        .arr_tag_way0(arr_tag_way0), .arr_tag_way1(arr_tag_way1),
        .arr_data_way0(arr_data_way0), .arr_data_way1(arr_data_way1)
    );

    // Behavioural 2-way x 4-set array with its own valid-clearing reset.
    logic        v_m [2][4];
    logic        d_m [2][4];
    logic [27:0] t_m [2][4];
    logic [31:0] dat_m [2][4];
    always @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 4; s++) begin
                    v_m[w][s] <= 1'b0; d_m[w][s] <= 1'b0; t_m[w][s] <= '0; dat_m[w][s] <= '0;
                end
        end else if (arr_write_en) begin
            v_m[arr_victim_way][arr_index]   <= arr_v_write;
            d_m[arr_victim_way][arr_index]   <= arr_dirty_write;
            t_m[arr_victim_way][arr_index]   <= arr_tag_write;
            dat_m[arr_victim_way][arr_index] <= arr_data_write;
        end
    end
    assign arr_v_way0     = v_m[0][arr_index];
    assign arr_v_way1     = v_m[1][arr_index];
    assign arr_dirty_way0 = d_m[0][arr_index];
    assign arr_dirty_way1 = d_m[1][arr_index];
    assign arr_tag_way0   = t_m[0][arr_index];
    assign arr_tag_way1   = t_m[1][arr_index];
    assign arr_data_way0  = dat_m[0][arr_index];
    assign arr_data_way1  = dat_m[1][arr_index];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: checks each new request against the queue, then holds it ack_delay cycles.
    initial begin : mem_model
        logic        in_req, h_we;
        logic [31:0] h_addr, h_wd, cur_rd;
        int          wcnt;
        mem_exp_t    e;
        auto_ack = 0; auto_rdata = 0; in_req = 0; wcnt = 0;
        h_we = 0; h_addr = 0; h_wd = 0; cur_rd = 0;
        forever begin
            @(negedge clk);
            auto_ack = 0; auto_rdata = 0;
            if (mem_req) mem_req_cyc++;
            if (mem_auto && mem_req && !rst) begin
                if (!in_req) begin
                    in_req = 1; wcnt = 0;
                    h_we = mem_we; h_addr = mem_addr; h_wd = mem_wdata;
                    if (exp_mem.size() == 0) begin
                        chk("mem_unexpected_req", mem_addr, 32'hFFFF_FFFF);
                        cur_rd = 0;
                    end else begin
                        e = exp_mem.pop_front();
                        chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                        chk("mem_addr", mem_addr, e.addr);
                        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                        cur_rd = e.rdata;
                    end
                end else begin
                    chk("mem_addr_hold", mem_addr, h_addr);
                    chk("mem_we_hold", {31'd0, mem_we}, {31'd0, h_we});
                    if (h_we) chk("mem_wdata_hold", mem_wdata, h_wd);
                    chk("ready_while_mem", {31'd0, cpu_ready}, 32'd0);
                end
                if (wcnt == ack_delay) begin
                    auto_ack = 1; auto_rdata = cur_rd; in_req = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin : resp_mon
        resp_exp_t r;
        if (cpu_resp_valid) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            if (exp_resp.size() == 0) chk("resp_unexpected", cpu_rdata, 32'hFFFF_FFFF);
            else begin
                r = exp_resp.pop_front();
                if (r.chk) chk("cpu_rdata", cpu_rdata, r.rdata);
            end
        end
    end

    always @(negedge clk) begin : arr_mon
        arr_exp_t a;
        if (arr_write_en) begin
            if (exp_arr.size() == 0) chk("arr_unexpected_write", {30'd0, arr_index}, 32'hFFFF_FFFF);
            else begin
                a = exp_arr.pop_front();
                chk("arr_way", {31'd0, arr_victim_way}, {31'd0, a.way});
                chk("arr_index", {30'd0, arr_index}, {30'd0, a.idx});
                chk("arr_v", {31'd0, arr_v_write}, 32'd1);
                chk("arr_tag", {4'd0, arr_tag_write}, {4'd0, a.tag});
                chk("arr_data", arr_data_write, a.data);
                chk("arr_dirty", {31'd0, arr_dirty_write}, {31'd0, a.dirty});
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input bit wait_resp, input int exp_lat);
        int n, start;
        n = 0;
        @(negedge clk);
        while (!cpu_ready && n < 100) begin @(negedge clk); n++; end
        chk("ready_before_issue", {31'd0, cpu_ready}, 32'd1);
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        start = resp_cnt; acc_cyc = cyc;
        @(posedge clk);
        #1 cpu_req = 0;
        if (wait_resp) begin
            n = 0;
            while (resp_cnt == start && n < 200) begin @(negedge clk); #1; n++; end
            chk("resp_arrived", {31'd0, resp_cnt != start}, 32'd1);
            if (exp_lat > 0) chk("resp_latency", last_resp_cyc - acc_cyc, exp_lat);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int m0, n;
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_auto = 1; ack_delay = 3; man_ack = 0; man_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_resp", {31'd0, cpu_resp_valid}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_arr_wen", {31'd0, arr_write_en}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        rst = 0;
        #1 chk("ready_after_rst", {31'd0, cpu_ready}, 32'd1);

        // Clean load miss into empty set 0 -> way0.
        exp_mem.push_back('{1'b0, 32'h100, 32'h0, 32'hDEADBEEF});
        exp_arr.push_back('{1'b0, 2'd0, 28'h10, 32'hDEADBEEF, 1'b0});
        exp_resp.push_back('{1'b1, 32'hDEADBEEF});
        issue(0, 32'h100, 0, 1, 0);

        // Load hit: one cycle, no memory traffic.
        m0 = mem_req_cyc;
        exp_resp.push_back('{1'b1, 32'hDEADBEEF});
        issue(0, 32'h100, 0, 1, 1);
        chk("hit_no_mem", mem_req_cyc - m0, 0);

        // Store miss fills the invalid way1 as dirty.
        exp_arr.push_back('{1'b1, 2'd0, 28'h11, 32'h11111111, 1'b1});
`ifdef CACHE_CTRL_WRITE_NOFETCH_EN
        exp_resp.push_back('{1'b0, 32'h0});
        issue(1, 32'h110, 32'h11111111, 1, 1);
`else
        exp_mem.push_back('{1'b0, 32'h110, 32'h0, 32'h55555555});
        exp_resp.push_back('{1'b1, 32'h55555555});
        issue(1, 32'h110, 32'h11111111, 1, 0);
`endif

        // Hit way0 so LRU points at dirty way1.
        exp_resp.push_back('{1'b1, 32'hDEADBEEF});
        issue(0, 32'h100, 0, 1, 1);

        // Dirty miss with a slow memory: writeback held 6 cycles, then refill into way1.
        ack_delay = 6;
        exp_mem.push_back('{1'b1, 32'h110, 32'h11111111, 32'h0});
        exp_mem.push_back('{1'b0, 32'h120, 32'h0, 32'h22222222});
        exp_arr.push_back('{1'b1, 2'd0, 28'h12, 32'h22222222, 1'b0});
        exp_resp.push_back('{1'b1, 32'h22222222});
        issue(0, 32'h120, 0, 1, 0);
        ack_delay = 3;

        // Reset in the middle of a refill; acks during and after reset must be ignored.
        mem_auto = 0;
        issue(0, 32'h130, 0, 0, 0);
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        chk("rf_req", {31'd0, mem_req}, 32'd1);
        chk("rf_addr", mem_addr, 32'h130);
        chk("rf_we", {31'd0, mem_we}, 32'd0);
        rst = 1; man_ack = 1; man_rdata = 32'hBAD0BAD0;
        #1;
        chk("ack_in_rst_wen", {31'd0, arr_write_en}, 32'd0);
        chk("ack_in_rst_resp", {31'd0, cpu_resp_valid}, 32'd0);
        chk("ack_in_rst_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 0; man_ack = 0;
        #1;
        chk("post_rst_req", {31'd0, mem_req}, 32'd0);
        chk("post_rst_wen", {31'd0, arr_write_en}, 32'd0);
        chk("post_rst_ready", {31'd0, cpu_ready}, 32'd1);
        @(negedge clk);
        man_ack = 1;
        #1;
        chk("late_ack_wen", {31'd0, arr_write_en}, 32'd0);
        chk("late_ack_resp", {31'd0, cpu_resp_valid}, 32'd0);
        @(negedge clk);
        man_ack = 0; man_rdata = 0; mem_auto = 1;

        // Store miss to a clean victim after reset, then read the stored word back.
        exp_arr.push_back('{1'b0, 2'd0, 28'h13, 32'h33333333, 1'b1});
`ifdef CACHE_CTRL_WRITE_NOFETCH_EN
        m0 = mem_req_cyc;
        exp_resp.push_back('{1'b0, 32'h0});
        issue(1, 32'h130, 32'h33333333, 1, 1);
        chk("nofetch_no_mem", mem_req_cyc - m0, 0);
`else
        exp_mem.push_back('{1'b0, 32'h130, 32'h0, 32'h44444444});
        exp_resp.push_back('{1'b1, 32'h44444444});
        issue(1, 32'h130, 32'h33333333, 1, 0);
`endif
        exp_resp.push_back('{1'b1, 32'h33333333});
        issue(0, 32'h130, 0, 1, 1);

        repeat (3) @(negedge clk);
        chk("mem_queue_drained", exp_mem.size(), 0);
        chk("arr_queue_drained", exp_arr.size(), 0);
        chk("resp_queue_drained", exp_resp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
